// File: rtl/mbm_pkg.sv
// Shared defaults for the multiplier/antilog datapath: log field widths,
// the bias-correction constant and the derived product width.
package mbm_pkg;

   localparam int CHAR_W_DEF = 4;
   localparam int FRAC_W_DEF = 7;
   localparam int BIAS_K_DEF = 5;

   // Product width: a k-bit characteristic can place the leading one at bit 2**k-1.
   function automatic int out_w(input int char_w);
      return 2 ** char_w;
   endfunction

   localparam int OUT_W_DEF = out_w(CHAR_W_DEF);

endpackage

// File: rtl/antilog_shift.sv
// Combinational antilog shifter: places mantissa {1,f} so that its leading
// one lands at bit k, truncating whatever falls below bit 0.
module antilog_shift
   import mbm_pkg::*;
#(
   parameter  int CHAR_W = CHAR_W_DEF,
   parameter  int FRAC_W = FRAC_W_DEF,
   localparam int OUT_W  = out_w(CHAR_W)
)(
   input  logic [FRAC_W:0]   i_mant,
   input  logic [CHAR_W-1:0] i_char,
   output logic [OUT_W-1:0]  o_data
);

   logic [OUT_W+FRAC_W-1:0] w_wide;

   // (m << k) >> FRAC_W covers both the k >= FRAC_W and k < FRAC_W cases in
   // one shifter; the widest case (k max, m all ones) still fits in OUT_W.
   assign w_wide = {{(OUT_W-1){1'b0}}, i_mant} << i_char;
   assign o_data = OUT_W'(w_wide >> FRAC_W);

endmodule

// File: rtl/antilog_conv.sv
// Two-stage elastic antilog converter (log domain -> approximate product).
// Optional saturating fraction bias correction: define ANTILOG_BIAS_CORR_EN.
module antilog_conv
   import mbm_pkg::*;
#(
   parameter  int CHAR_W = CHAR_W_DEF,
   parameter  int FRAC_W = FRAC_W_DEF,
   parameter  int BIAS_K = BIAS_K_DEF,
   localparam int OUT_W  = out_w(CHAR_W)
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CHAR_W-1:0] in_char,
   input  logic [FRAC_W-1:0] in_frac,
   input  logic              in_zero,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data
);

   if (BIAS_K < 0 || BIAS_K >= 2 ** FRAC_W) begin : g_bad_bias
      $error("antilog_conv: BIAS_K must lie in [0, 2**FRAC_W)");
   end

   logic              r_s1_valid;
   logic              r_s1_zero;
   logic [CHAR_W-1:0] r_s1_char;
   logic [FRAC_W:0]   r_s1_mant;
   logic              r_out_valid;
   logic [OUT_W-1:0]  r_out_data;

   logic              w_s2_ld;
   logic              w_s1_adv;
   logic              w_in_ready;
   logic [FRAC_W-1:0] w_frac_c;
   logic [OUT_W-1:0]  w_shifted;

`ifdef ANTILOG_BIAS_CORR_EN
   logic [FRAC_W:0] w_frac_sum;

   // Saturate instead of carrying into k: a carry would double the result.
   assign w_frac_sum = {1'b0, in_frac} + (FRAC_W+1)'(BIAS_K);
   assign w_frac_c   = w_frac_sum[FRAC_W] ? '1 : w_frac_sum[FRAC_W-1:0];
`else
   assign w_frac_c   = in_frac;
`endif

   assign w_s2_ld    = !r_out_valid || out_ready;
   assign w_s1_adv   = r_s1_valid && w_s2_ld;
   assign w_in_ready = !r_s1_valid || w_s1_adv;

   assign in_ready   = w_in_ready;
   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_zero  <= 1'b0;
         r_s1_char  <= '0;
         r_s1_mant  <= '0;
      end else if (w_in_ready) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_zero <= in_zero;
            r_s1_char <= in_char;
            r_s1_mant <= {1'b1, w_frac_c};
         end
      end
   end

   antilog_shift #(
      .CHAR_W (CHAR_W),
      .FRAC_W (FRAC_W)
   ) u_shift (
      .i_mant (r_s1_mant),
      .i_char (r_s1_char),
      .o_data (w_shifted)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (w_s2_ld) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid)
            r_out_data <= r_s1_zero ? '0 : w_shifted;
      end
   end

endmodule
